// File: rtl/dcache_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dcache_pkg
// Description : Shared widths, FSM state type and memory-port opcodes for the
//               direct-mapped write-through L1 data cache.
// Revision    : 1.0 - initial release
// ============================================================================
package dcache_pkg;

    // Default cache geometry; the top level may override these per instance.
    localparam int DEF_NUM_LINES      = 64;
    localparam int DEF_WORDS_PER_LINE = 4;
    localparam int DEF_ADDR_W         = 32;

    // Address-split widths for the default geometry.
    localparam int WCNT_W   = $clog2(DEF_WORDS_PER_LINE);
    localparam int OFFSET_W = WCNT_W + 2;
    localparam int INDEX_W  = $clog2(DEF_NUM_LINES);
    localparam int TAG_W    = DEF_ADDR_W - INDEX_W - OFFSET_W;

    // Memory-port direction encoding.
    localparam logic MEM_READ  = 1'b0;
    localparam logic MEM_WRITE = 1'b1;

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        REFILL = 1'b1
    } state_e;

endpackage : dcache_pkg
`default_nettype wire

// File: rtl/dcache_write_buffer.sv
`default_nettype none
// ============================================================================
// Module      : dcache_write_buffer
// Description : One-entry store buffer. A push always wins over a drain ack
//               in the same cycle, so a store accepted on the drain's ack
//               edge simply replaces the departing entry.
// Revision    : 1.0 - initial release
// ============================================================================
module dcache_write_buffer #(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push_in,
    input  logic [ADDR_W-3:0] addr_in,
    input  logic [31:0]       data_in,
    input  logic [3:0]        byte_en_in,
    input  logic              ack_in,
    output logic              empty_out,
    output logic              full_out,
    output logic [ADDR_W-3:0] addr_out,
    output logic [31:0]       data_out,
    output logic [3:0]        byte_en_out
);

    logic              valid_q, valid_d;
    logic [ADDR_W-3:0] addr_q, addr_d;
    logic [31:0]       data_q, data_d;
    logic [3:0]        be_q, be_d;

    // Next entry: capture on push, otherwise retire on drain ack.
    always_comb begin
        valid_d = valid_q;
        addr_d  = addr_q;
        data_d  = data_q;
        be_d    = be_q;
        if (push_in) begin
            valid_d = 1'b1;
            addr_d  = addr_in;
            data_d  = data_in;
            be_d    = byte_en_in;
        end else if (ack_in) begin
            valid_d = 1'b0;
        end
    end

    // Entry register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
            be_q    <= '0;
        end else begin
            valid_q <= valid_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            be_q    <= be_d;
        end
    end

    assign empty_out   = !valid_q;
    assign full_out    = valid_q;
    assign addr_out    = addr_q;
    assign data_out    = data_q;
    assign byte_en_out = be_q;

endmodule : dcache_write_buffer
`default_nettype wire

// File: rtl/dcache.sv
`default_nettype none
// ============================================================================
// Module      : dcache
// Description : Direct-mapped, write-through, no-write-allocate L1 data cache
//               with a one-entry store buffer and line refill over a
//               request/acknowledge memory port.
// Revision    : 1.0 - initial release
// ============================================================================
module dcache
    import dcache_pkg::*;
#(
    parameter int NUM_LINES      = DEF_NUM_LINES,
    parameter int WORDS_PER_LINE = DEF_WORDS_PER_LINE,
    parameter int ADDR_W         = DEF_ADDR_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en_read_in,
    input  logic              en_write_in,
    input  logic [3:0]        byte_en_in,
    input  logic [ADDR_W-1:0] addr_in,
    input  logic [31:0]       wdata_in,
    output logic [31:0]       rdata_out,
    output logic              ready_out,
    output logic              mem_req_out,
    output logic              mem_we_out,
    output logic [ADDR_W-1:0] mem_addr_out,
    output logic [31:0]       mem_wdata_out,
    output logic [3:0]        mem_byte_en_out,
    input  logic [31:0]       mem_rdata_in,
    input  logic              mem_ack_in
);

    localparam int CNT_BITS = $clog2(WORDS_PER_LINE);
    localparam int OFF_BITS = CNT_BITS + 2;
    localparam int IDX_BITS = $clog2(NUM_LINES);
    localparam int TAG_BITS = ADDR_W - IDX_BITS - OFF_BITS;
    localparam logic [CNT_BITS-1:0] LAST_WORD = CNT_BITS'(WORDS_PER_LINE - 1);

    logic [CNT_BITS-1:0] req_word;
    logic [IDX_BITS-1:0] req_idx;
    logic [TAG_BITS-1:0] req_tag;
    logic                unused_addr_lsb;

    assign req_word        = addr_in[OFF_BITS-1:2];
    assign req_idx         = addr_in[OFF_BITS+IDX_BITS-1:OFF_BITS];
    assign req_tag         = addr_in[ADDR_W-1:OFF_BITS+IDX_BITS];
    assign unused_addr_lsb = ^addr_in[1:0];

    // Only the valid bits need reset; tags and data are qualified by them.
    logic [NUM_LINES-1:0] valid_q, valid_d;
    logic [TAG_BITS-1:0]  tag_q  [NUM_LINES];
    logic [31:0]          data_q [NUM_LINES][WORDS_PER_LINE];

    state_e              state_q, state_d;
    logic [CNT_BITS-1:0] wcnt_q, wcnt_d;
    logic [IDX_BITS-1:0] fill_idx_q, fill_idx_d;
    logic [TAG_BITS-1:0] fill_tag_q, fill_tag_d;

    logic              hit;
    logic              is_write;
    logic              wb_empty, wb_full, wb_push, wb_ack;
    logic [ADDR_W-3:0] wb_addr;
    logic [31:0]       wb_data;
    logic [3:0]        wb_be;
    logic              fill_we, merge_we, tag_we;

    assign hit      = valid_q[req_idx] && (tag_q[req_idx] == req_tag);
    // A simultaneous read and write is illegal; the read takes precedence.
    assign is_write = en_write_in && !en_read_in;

    dcache_write_buffer #(
        .ADDR_W (ADDR_W)
    ) u_wbuf (
        .clk         (clk),
        .rst_n       (rst_n),
        .push_in     (wb_push),
        .addr_in     (addr_in[ADDR_W-1:2]),
        .data_in     (wdata_in),
        .byte_en_in  (byte_en_in),
        .ack_in      (wb_ack),
        .empty_out   (wb_empty),
        .full_out    (wb_full),
        .addr_out    (wb_addr),
        .data_out    (wb_data),
        .byte_en_out (wb_be)
    );

    // Next-state, handshake and memory-port mux; drain has priority because
    // a refill is only started once the buffer is empty.
    always_comb begin
        state_d         = state_q;
        wcnt_d          = wcnt_q;
        fill_idx_d      = fill_idx_q;
        fill_tag_d      = fill_tag_q;
        valid_d         = valid_q;
        ready_out       = 1'b1;
        rdata_out       = '0;
        mem_req_out     = 1'b0;
        mem_we_out      = MEM_READ;
        mem_addr_out    = '0;
        mem_wdata_out   = '0;
        mem_byte_en_out = '0;
        wb_push         = 1'b0;
        wb_ack          = 1'b0;
        fill_we         = 1'b0;
        merge_we        = 1'b0;
        tag_we          = 1'b0;
        case (state_q)
            IDLE: begin
                if (wb_full) begin
                    mem_req_out     = 1'b1;
                    mem_we_out      = MEM_WRITE;
                    mem_addr_out    = {wb_addr, 2'b00};
                    mem_wdata_out   = wb_data;
                    mem_byte_en_out = wb_be;
                    wb_ack          = mem_ack_in;
                end
                if (en_read_in) begin
                    if (hit) begin
                        rdata_out = data_q[req_idx][req_word];
                    end else begin
                        ready_out = 1'b0;
                        // Loads may not overtake a buffered store.
                        if (wb_empty) begin
                            state_d    = REFILL;
                            wcnt_d     = '0;
                            fill_idx_d = req_idx;
                            fill_tag_d = req_tag;
                        end
                    end
                end else if (is_write) begin
                    ready_out = wb_empty || wb_ack;
                    wb_push   = ready_out;
                    merge_we  = ready_out && hit;
                end
            end
            REFILL: begin
                ready_out    = !(en_read_in || en_write_in);
                mem_req_out  = 1'b1;
                mem_we_out   = MEM_READ;
                mem_addr_out = {fill_tag_q, fill_idx_q, wcnt_q, 2'b00};
                if (mem_ack_in) begin
                    fill_we = 1'b1;
                    wcnt_d  = wcnt_q + 1'b1;
                    if (wcnt_q == LAST_WORD) begin
                        tag_we              = 1'b1;
                        valid_d[fill_idx_q] = 1'b1;
                        state_d             = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Control state: FSM, refill counter, latched refill line, valid bits.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            wcnt_q     <= '0;
            fill_idx_q <= '0;
            fill_tag_q <= '0;
            valid_q    <= '0;
        end else begin
            state_q    <= state_d;
            wcnt_q     <= wcnt_d;
            fill_idx_q <= fill_idx_d;
            fill_tag_q <= fill_tag_d;
            valid_q    <= valid_d;
        end
    end

    // Tag/data arrays: refill words, refill tag, and store-hit byte merge.
    always_ff @(posedge clk) begin
        if (tag_we) begin
            tag_q[fill_idx_q] <= fill_tag_q;
        end
        if (fill_we) begin
            data_q[fill_idx_q][wcnt_q] <= mem_rdata_in;
        end
        if (merge_we) begin
            for (int b = 0; b < 4; b++) begin
                if (byte_en_in[b]) begin
                    data_q[req_idx][req_word][8*b +: 8] <= wdata_in[8*b +: 8];
                end
            end
        end
    end

    a_no_read_and_write: assert property (
        @(posedge clk) disable iff (!rst_n) !(en_read_in && en_write_in)
    );

endmodule : dcache
`default_nettype wire

// File: tb/tb_dcache.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_dcache
// Description : Scoreboard bench for dcache: directed scenarios followed by
//               random loads/stores against a flat-memory reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dcache;

    localparam int MEM_WORDS = 16384;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en_read_in, en_write_in;
    logic [3:0]  byte_en_in;
    logic [31:0] addr_in, wdata_in, rdata_out;
    logic        ready_out, mem_req_out, mem_we_out;
    logic [31:0] mem_addr_out, mem_wdata_out, mem_rdata_in;
    logic [3:0]  mem_byte_en_out;
    logic        mem_ack_in;

    dcache dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .en_read_in      (en_read_in),
        .en_write_in     (en_write_in),
        .byte_en_in      (byte_en_in),
        .addr_in         (addr_in),
        .wdata_in        (wdata_in),
        .rdata_out       (rdata_out),
        .ready_out       (ready_out),
        .mem_req_out     (mem_req_out),
        .mem_we_out      (mem_we_out),
        .mem_addr_out    (mem_addr_out),
        .mem_wdata_out   (mem_wdata_out),
        .mem_byte_en_out (mem_byte_en_out),
        .mem_rdata_in    (mem_rdata_in),
        .mem_ack_in      (mem_ack_in)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  be;
    } wr_t;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] dev_mem   [MEM_WORDS];   // contents of the memory device
    logic [31:0] model_mem [MEM_WORDS];   // architectural memory (program order)
    bit          line_valid [64];
    int          line_tag   [64];
    logic [31:0] exp_rd_q [$];
    wr_t         exp_wr_q [$];
    int          ack_lat = 0;
    int          wait_cnt = 0;
    int          refill_k = 0;
    logic [31:0] refill_base = '0;
    bit          fr;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic bit model_hit(input logic [31:0] a);
        return line_valid[a[9:4]] && (line_tag[a[9:4]] == int'(a[31:10]));
    endfunction

    // Memory device: acks after ack_lat idle cycles, checks stores and refill order.
    initial begin
        mem_ack_in   = 1'b0;
        mem_rdata_in = '0;
        forever begin
            @(posedge clk);
            #1;
            mem_ack_in = 1'b0;
            if (rst_n && mem_req_out) begin
                if (wait_cnt >= ack_lat) begin
                    wait_cnt   = 0;
                    mem_ack_in = 1'b1;
                    if (mem_we_out) begin
                        if (exp_wr_q.size() == 0) begin
                            checks++;
                            errors++;
                            $display("FAIL unexpected_mem_write: got addr %h expected none", mem_addr_out);
                        end else begin
                            wr_t e;
                            e = exp_wr_q.pop_front();
                            chk("mem_write_addr", mem_addr_out, e.addr);
                            chk("mem_write_data", mem_wdata_out, e.data);
                            chk("mem_write_be", {28'd0, mem_byte_en_out}, {28'd0, e.be});
                        end
                        for (int b = 0; b < 4; b++)
                            if (mem_byte_en_out[b])
                                dev_mem[mem_addr_out[15:2]][8*b +: 8] = mem_wdata_out[8*b +: 8];
                    end else begin
                        chk("refill_addr", mem_addr_out, refill_base + 32'(refill_k * 4));
                        refill_k++;
                        mem_rdata_in = dev_mem[mem_addr_out[15:2]];
                    end
                end else begin
                    wait_cnt++;
                end
            end else begin
                wait_cnt = 0;
            end
        end
    end

    // Load monitor: compares returned data whenever a load is serviced.
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n && en_read_in && ready_out) begin
                if (exp_rd_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_load: got %h expected none", rdata_out);
                end else begin
                    chk("load_data", rdata_out, exp_rd_q.pop_front());
                end
            end
        end
    end

    task automatic do_read(input logic [31:0] a);
        bit exp_hit;
        int cyc;
        bit to;
        exp_hit = model_hit(a);
        exp_rd_q.push_back(model_mem[a[15:2]]);
        refill_base = {a[31:4], 4'b0000};
        refill_k    = 0;
        en_read_in  = 1'b1;
        addr_in     = a;
        cyc = 0;
        to  = 1'b0;
        @(negedge clk);
        while (!ready_out && !to) begin
            cyc++;
            if (cyc > 300) to = 1'b1;
            else @(negedge clk);
        end
        if (to) begin
            checks++;
            errors++;
            $display("FAIL read_timeout: got no ready expected ready for addr %h", a);
            void'(exp_rd_q.pop_back());
        end else begin
            chk("read_hit_latency", 32'(cyc == 0), 32'(exp_hit));
            chk("refill_word_count", refill_k, exp_hit ? 0 : 4);
        end
        @(posedge clk);
        #2;
        en_read_in = 1'b0;
        line_valid[a[9:4]] = 1'b1;
        line_tag[a[9:4]]   = int'(a[31:10]);
    endtask

    task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be,
                            output bit first_rdy);
        int cyc;
        bit to;
        bit was_empty;
        was_empty   = (exp_wr_q.size() == 0);
        en_write_in = 1'b1;
        addr_in     = a;
        wdata_in    = d;
        byte_en_in  = be;
        cyc = 0;
        to  = 1'b0;
        @(negedge clk);
        first_rdy = ready_out;
        while (!ready_out && !to) begin
            cyc++;
            if (cyc > 300) to = 1'b1;
            else @(negedge clk);
        end
        if (to) begin
            checks++;
            errors++;
            $display("FAIL write_timeout: got no ready expected ready for addr %h", a);
        end else begin
            if (was_empty) chk("write_immediate", 32'(first_rdy), 32'd1);
            for (int b = 0; b < 4; b++)
                if (be[b]) model_mem[a[15:2]][8*b +: 8] = d[8*b +: 8];
            exp_wr_q.push_back(wr_t'{addr: {a[31:2], 2'b00}, data: d, be: be});
        end
        @(posedge clk);
        #2;
        en_write_in = 1'b0;
    endtask

    task automatic wait_drain();
        int cyc;
        cyc = 0;
        while (exp_wr_q.size() != 0 && cyc < 200) begin
            @(posedge clk);
            #2;
            cyc++;
        end
        @(posedge clk);
        #2;
        chk("store_drain_complete", exp_wr_q.size(), 0);
    endtask

    task automatic reset_mid_refill(input logic [31:0] a);
        int cyc;
        refill_base = {a[31:4], 4'b0000};
        refill_k    = 0;
        en_read_in  = 1'b1;
        addr_in     = a;
        cyc = 0;
        @(negedge clk);
        while (refill_k < 2 && cyc < 100) begin
            cyc++;
            @(negedge clk);
        end
        chk("refill_acks_before_reset", refill_k, 2);
        #1;
        rst_n      = 1'b0;
        en_read_in = 1'b0;
        #1;
        chk("reset_mem_req_async", 32'(mem_req_out), 32'd0);
        chk("reset_ready", 32'(ready_out), 32'd1);
        for (int i = 0; i < 64; i++) line_valid[i] = 1'b0;
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        @(posedge clk);
        #2;
        do_read(a);
    endtask

    initial begin
        logic [31:0] a;
        en_read_in  = 1'b0;
        en_write_in = 1'b0;
        byte_en_in  = '0;
        addr_in     = '0;
        wdata_in    = '0;
        for (int i = 0; i < MEM_WORDS; i++) begin
            dev_mem[i]   = $urandom;
            model_mem[i] = dev_mem[i];
        end
        dev_mem[64] = 32'hA0A0_0000;
        dev_mem[65] = 32'h1122_3344;
        dev_mem[66] = 32'hA2A2_2222;
        dev_mem[67] = 32'hA3A3_3333;
        for (int i = 64; i < 68; i++) model_mem[i] = dev_mem[i];
        for (int i = 0; i < 64; i++) begin
            line_valid[i] = 1'b0;
            line_tag[i]   = 0;
        end

        repeat (3) @(posedge clk);
        #2;
        chk("reset_ready_out", 32'(ready_out), 32'd1);
        chk("reset_mem_req", 32'(mem_req_out), 32'd0);
        chk("reset_mem_we", 32'(mem_we_out), 32'd0);
        chk("reset_rdata", rdata_out, 32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #2;
        chk("idle_ready_out", 32'(ready_out), 32'd1);
        chk("idle_mem_req", 32'(mem_req_out), 32'd0);

        // Cold miss with 2-cycle acks, then a same-line hit.
        ack_lat = 2;
        do_read(32'h0000_0100);
        do_read(32'h0000_0108);

        // Store hit with partial byte lanes, then reload the merged word.
        do_write(32'h0000_0104, 32'hAABB_CCDD, 4'b0011, fr);
        do_read(32'h0000_0104);

        // Back-to-back stores with slow memory: the second must stall.
        ack_lat = 3;
        do_write(32'h0000_0200, 32'h1234_5678, 4'b1111, fr);
        do_write(32'h0000_0204, 32'h9ABC_DEF0, 4'b1111, fr);
        chk("second_store_stalled", 32'(fr), 32'd0);

        // Store miss does not allocate; the load waits for the drain.
        ack_lat = 1;
        do_write(32'h0000_2000, 32'hDEAD_BEEF, 4'b1111, fr);
        do_read(32'h0000_2000);

        // Conflict eviction on one index.
        ack_lat = 0;
        do_read(32'h0000_0000);
        do_read(32'h0000_0400);
        do_read(32'h0000_0000);

        // Reset in the middle of a refill.
        wait_drain();
        ack_lat = 1;
        reset_mid_refill(32'h0000_3040);

        // Random traffic over a few tags and indices to mix hits and misses.
        for (int n = 0; n < 200; n++) begin
            a = ($urandom % 4) << 10 | ($urandom % 8) << 4 | ($urandom % 4) << 2;
            ack_lat = $urandom % 3;
            if ($urandom % 2) do_read(a);
            else do_write(a, $urandom, 4'($urandom % 16), fr);
            repeat ($urandom % 3) @(posedge clk);
            #2;
        end

        wait_drain();
        chk("loads_all_returned", exp_rd_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule : tb_dcache
`default_nettype wire
